// File: rtl/rtlola_monitor_pkg.sv
// Shared types for the RTLola tight-pipeline monitor: stream width, the
// event-queue entry layout and the per-layer pacing bundles.
package rtlola_monitor_pkg;

  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] data_t;

  // One queue entry: input values, their presence flags and the periodic deadline.
  typedef struct packed {
    data_t v0;
    data_t v1;
    data_t v2;
    logic  n0;
    logic  n1;
    logic  n2;
    logic  dl;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Pacing decided at layer 0 for every stream of the specification.
  typedef struct packed {
    logic in0;
    logic in1;
    logic in2;
    logic out0;
    logic out1;
    logic out2;
    logic out3;
    logic out4;
  } l0_pacing_t;

  // Pacing carried into layer 1 (out2 evaluated here, out3 still pending).
  typedef struct packed {
    logic out2;
    logic out3;
  } l1_pacing_t;

  // Pacing carried into layer 2 (out3 evaluated here).
  typedef struct packed {
    logic out3;
  } l2_pacing_t;

  // Pacing rules of the fixed specification, applied to one entry.
  function automatic l0_pacing_t pace_of(input entry_t e);
    l0_pacing_t p;
    p.in0  = e.n0;
    p.in1  = e.n1;
    p.in2  = e.n2;
    p.out0 = e.n0 & e.n1;
    p.out1 = e.n1 & e.n2;
    p.out2 = e.n0 & e.n1 & e.n2;
    p.out3 = e.n0 & e.n1 & e.n2;
    p.out4 = e.dl;
    return p;
  endfunction

endpackage

// File: rtl/rtlola_event_fifo.sv
// Event queue for the monitor. push/pop are already qualified by the caller
// (push only when accepted, pop only when non-empty); head is read combinationally.
module rtlola_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the empty count guarantees stale words are never consumed.
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rtlola_tight_pipeline_monitor.sv
// RTLola monitor: inputs and periodic deadlines are queued, then evaluated by a
// three-layer overlapping pipeline (out0/out1/out4, then out2, then out3).
// Build option OUTPUT_HOLD_EN: outputs keep their last evaluated value instead
// of reading 0 while their aktv strobe is low.
module rtlola_tight_pipeline_monitor
  import rtlola_monitor_pkg::*;
#(
  parameter int Q_DEPTH       = 4,
  parameter int PERIOD_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] input_0,
  input  logic [DATA_W-1:0] input_1,
  input  logic [DATA_W-1:0] input_2,
  input  logic              new_input_0,
  input  logic              new_input_1,
  input  logic              new_input_2,
  output logic [DATA_W-1:0] output_0,
  output logic [DATA_W-1:0] output_1,
  output logic [DATA_W-1:0] output_2,
  output logic [DATA_W-1:0] output_3,
  output logic [DATA_W-1:0] output_4,
  output logic              output_0_aktv,
  output logic              output_1_aktv,
  output logic              output_2_aktv,
  output logic              output_3_aktv,
  output logic              output_4_aktv,
  output logic              q_push,
  output logic              q_pop,
  output logic              q_push_valid,
  output logic              q_pop_valid,
  output logic              pacing_in0,
  output logic              pacing_in1,
  output logic              pacing_in2,
  output logic              pacing_out0_0,
  output logic              pacing_out1_0,
  output logic              pacing_out2_0,
  output logic              pacing_out3_0,
  output logic              pacing_out4_0,
  output logic              pacing_out2_1,
  output logic              pacing_out3_1,
  output logic              pacing_out3_2,
  output logic              slide_0
);

  localparam int TW = ($clog2(PERIOD_CYCLES) > 0) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PERIOD_CYCLES - 1);

  logic [TW-1:0] tmr;
  logic          deadline;
  logic          q_full, q_empty;
  entry_t        push_entry, head;

  // Layer registers.
  logic       l0_v;
  entry_t     l0_e;
  l0_pacing_t l0_p;
  l1_pacing_t l1_p;
  data_t      l1_o0, l1_v2, l1_hist;
  l2_pacing_t l2_p;
  data_t      l2_o2, l2_hist;

  // Window buckets and out0 history.
  data_t cur, prev, hist;

  // Combinational layer results.
  data_t o0, o1, o2, o3, o4, cur_eff;

  // Output stage, indexed by stream number.
  logic [4:0] stage_p;
  data_t      stage_v [5];
  logic [4:0] aktv_q;
  data_t      val_q   [5];

  // Period timer; frozen while en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  tmr <= '0;
    else if (en) tmr <= (tmr == T_LAST) ? '0 : tmr + TW'(1);
  end

  assign deadline     = en & (tmr == T_LAST);
  assign q_push       = en & (new_input_0 | new_input_1 | new_input_2 | deadline);
  assign q_pop        = en;
  assign q_pop_valid  = en & ~q_empty;
  assign q_push_valid = q_push & (~q_full | q_pop_valid);

  assign push_entry = '{v0: input_0, v1: input_1, v2: input_2,
                        n0: new_input_0, n1: new_input_1, n2: new_input_2,
                        dl: deadline};

  rtlola_event_fifo #(
    .DEPTH (Q_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push_valid),
    .pop   (q_pop_valid),
    .din   (push_entry),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

  assign l0_p = l0_v ? pace_of(l0_e) : '0;

  // Layer arithmetic, all wrapping modulo 2^DATA_W.
  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    cur_eff = cur + (l0_e.n0 ? l0_e.v0 : '0);
    o0      = l0_e.v0 + l0_e.v1;
    o1      = l0_e.v1 + l0_e.v2;
    o4      = cur_eff + prev;
    o2      = l1_o0 + l1_v2;
    o3      = l2_o2 + l2_hist;
    stage_p = {l0_p.out4, l2_p.out3, l1_p.out2, l0_p.out1, l0_p.out0};
    stage_v[0] = o0;
    stage_v[1] = o1;
    stage_v[2] = o2;
    stage_v[3] = o3;
    stage_v[4] = o4;
  end

  // Pipeline advance: pop into layer 0, then layers 1 and 2; history sampled before update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l0_v    <= 1'b0;
      l0_e    <= '0;
      l1_p    <= '0;
      l1_o0   <= '0;
      l1_v2   <= '0;
      l1_hist <= '0;
      l2_p    <= '0;
      l2_o2   <= '0;
      l2_hist <= '0;
      cur     <= '0;
      prev    <= '0;
      hist    <= '0;
    end else if (en) begin
      l0_v <= q_pop_valid;
      if (q_pop_valid) l0_e <= head;
      l1_p    <= '{out2: l0_p.out2, out3: l0_p.out3};
      l1_o0   <= o0;
      l1_v2   <= l0_e.v2;
      l1_hist <= hist;
      l2_p    <= '{out3: l1_p.out3};
      l2_o2   <= o2;
      l2_hist <= l1_hist;
      if (l0_p.out0) hist <= o0;
      if (l0_v) begin
        if (l0_e.dl) begin
          prev <= cur_eff;
          cur  <= '0;
        end else begin
          cur  <= cur_eff;
        end
      end
    end
  end

  // Output registers: strobe every evaluation, capture value when evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aktv_q <= '0;
      for (int i = 0; i < 5; i++) val_q[i] <= '0;
    end else if (en) begin
      aktv_q <= stage_p;
      for (int i = 0; i < 5; i++) if (stage_p[i]) val_q[i] <= stage_v[i];
    end
  end

  assign output_0_aktv = en & aktv_q[0];
  assign output_1_aktv = en & aktv_q[1];
  assign output_2_aktv = en & aktv_q[2];
  assign output_3_aktv = en & aktv_q[3];
  assign output_4_aktv = en & aktv_q[4];

`ifdef OUTPUT_HOLD_EN
  assign output_0 = val_q[0];
  assign output_1 = val_q[1];
  assign output_2 = val_q[2];
  assign output_3 = val_q[3];
  assign output_4 = val_q[4];
`else
  assign output_0 = output_0_aktv ? val_q[0] : '0;
  assign output_1 = output_1_aktv ? val_q[1] : '0;
  assign output_2 = output_2_aktv ? val_q[2] : '0;
  assign output_3 = output_3_aktv ? val_q[3] : '0;
  assign output_4 = output_4_aktv ? val_q[4] : '0;
`endif

  assign pacing_in0    = en & l0_p.in0;
  assign pacing_in1    = en & l0_p.in1;
  assign pacing_in2    = en & l0_p.in2;
  assign pacing_out0_0 = en & l0_p.out0;
  assign pacing_out1_0 = en & l0_p.out1;
  assign pacing_out2_0 = en & l0_p.out2;
  assign pacing_out3_0 = en & l0_p.out3;
  assign pacing_out4_0 = en & l0_p.out4;
  assign slide_0       = en & l0_p.out4;
  assign pacing_out2_1 = en & l1_p.out2;
  assign pacing_out3_1 = en & l1_p.out3;
  assign pacing_out3_2 = en & l2_p.out3;

endmodule

// File: tb/tb_rtlola_tight_pipeline_monitor.sv
// Directed bench for rtlola_tight_pipeline_monitor: a vector table for the
// stream arithmetic/pacing plus sequences for window, back-to-back, en and reset.
module tb_rtlola_tight_pipeline_monitor;
  import rtlola_monitor_pkg::*;

  localparam int P = 64;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  en = 1'b0;
  data_t in0, in1, in2;
  logic  n0, n1, n2;
  data_t output_0, output_1, output_2, output_3, output_4;
  logic  output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv, output_4_aktv;
  logic  q_push, q_pop, q_push_valid, q_pop_valid;
  logic  pacing_in0, pacing_in1, pacing_in2;
  logic  pacing_out0_0, pacing_out1_0, pacing_out2_0, pacing_out3_0, pacing_out4_0;
  logic  pacing_out2_1, pacing_out3_1, pacing_out3_2, slide_0;

  rtlola_tight_pipeline_monitor #(.Q_DEPTH(4), .PERIOD_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .input_0(in0), .input_1(in1), .input_2(in2),
    .new_input_0(n0), .new_input_1(n1), .new_input_2(n2),
    .output_0(output_0), .output_1(output_1), .output_2(output_2),
    .output_3(output_3), .output_4(output_4),
    .output_0_aktv(output_0_aktv), .output_1_aktv(output_1_aktv),
    .output_2_aktv(output_2_aktv), .output_3_aktv(output_3_aktv),
    .output_4_aktv(output_4_aktv),
    .q_push(q_push), .q_pop(q_pop), .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid),
    .pacing_in0(pacing_in0), .pacing_in1(pacing_in1), .pacing_in2(pacing_in2),
    .pacing_out0_0(pacing_out0_0), .pacing_out1_0(pacing_out1_0),
    .pacing_out2_0(pacing_out2_0), .pacing_out3_0(pacing_out3_0),
    .pacing_out4_0(pacing_out4_0), .pacing_out2_1(pacing_out2_1),
    .pacing_out3_1(pacing_out3_1), .pacing_out3_2(pacing_out3_2),
    .slide_0(slide_0)
  );

  always #5 clk = ~clk;

  typedef struct {
    data_t      i0, i1, i2;
    logic [2:0] nw;   // {n2, n1, n0}
    data_t      e0, e1, e2, e3;
    logic [3:0] ea;   // expected strobes {out3, out2, out1, out0}
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input data_t a, input data_t b, input data_t c, input logic [2:0] nw);
    in0 = a; in1 = b; in2 = c;
    n0 = nw[0]; n1 = nw[1]; n2 = nw[2];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    drive('0, '0, '0, 3'b000);
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  function automatic logic any_aktv();
    return output_0_aktv | output_1_aktv | output_2_aktv | output_3_aktv | output_4_aktv;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [7];
    data_t e0s [8];
    data_t e2s [8];
    data_t e3s [8];
    data_t exp4 [3];
    logic [7:0] epop;
    int    seen, slides;
    logic  prev_slide;

    vecs[0] = '{64'd1, 64'd1, 64'd1, 3'b111, 64'd2, 64'd2, 64'd3, 64'd3, 4'b1111};
    vecs[1] = '{64'd2, 64'd2, 64'd2, 3'b111, 64'd4, 64'd4, 64'd6, 64'd8, 4'b1111};
    vecs[2] = '{64'd8, 64'd0, 64'd8, 3'b101, 64'd0, 64'd0, 64'd0, 64'd0, 4'b0000};
    vecs[3] = '{-64'sd5, 64'd3, 64'd7, 3'b111, -64'sd2, 64'd10, 64'd5, 64'd9, 4'b1111};
    vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 3'b111,
                64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000,
                64'h7FFF_FFFF_FFFF_FFFE, 4'b1111};
    vecs[5] = '{64'd3, 64'd4, 64'd0, 3'b011, 64'd7, 64'd0, 64'd0, 64'd0, 4'b0001};
    vecs[6] = '{64'd1, 64'd1, 64'd1, 3'b111, 64'd2, 64'd2, 64'd3, 64'd10, 4'b1111};

    drive('0, '0, '0, 3'b000);
    #3;
    check("reset_out0", output_0, 64'd0);
    check("reset_aktv", {output_0_aktv, output_1_aktv, output_2_aktv, output_3_aktv, output_4_aktv}, 0);

    // Vector table: one entry at a time, checked at each pipeline layer.
    do_reset();
    for (int v = 0; v < 7; v++) begin
      step();
      drive(vecs[v].i0, vecs[v].i1, vecs[v].i2, vecs[v].nw);
      #1;
      check($sformatf("v%0d_push", v), q_push, 1'b1);
      check($sformatf("v%0d_push_valid", v), q_push_valid, 1'b1);
      step();
      drive('0, '0, '0, 3'b000);
      #1;
      check($sformatf("v%0d_pop_valid", v), q_pop_valid, 1'b1);
      step();
      check($sformatf("v%0d_pacing_in", v), {pacing_in2, pacing_in1, pacing_in0}, vecs[v].nw);
      check($sformatf("v%0d_pacing_l0", v),
            {pacing_out4_0, pacing_out3_0, pacing_out2_0, pacing_out1_0, pacing_out0_0},
            {1'b0, vecs[v].ea});
      step();
      check($sformatf("v%0d_out0", v), output_0, vecs[v].e0);
      check($sformatf("v%0d_out1", v), output_1, vecs[v].e1);
      check($sformatf("v%0d_aktv01", v), {output_1_aktv, output_0_aktv}, vecs[v].ea[1:0]);
      check($sformatf("v%0d_pacing_l1", v), {pacing_out3_1, pacing_out2_1},
            {vecs[v].ea[3], vecs[v].ea[2]});
      step();
      check($sformatf("v%0d_out2", v), output_2, vecs[v].e2);
      check($sformatf("v%0d_aktv2", v), output_2_aktv, vecs[v].ea[2]);
      check($sformatf("v%0d_pacing_l2", v), pacing_out3_2, vecs[v].ea[3]);
      step();
      check($sformatf("v%0d_out3", v), output_3, vecs[v].e3);
      check($sformatf("v%0d_aktv3", v), output_3_aktv, vecs[v].ea[3]);
    end

    // Back-to-back entries 9, 10, 11 on consecutive cycles.
    do_reset();
    e0s  = '{64'd0, 64'd0, 64'd0, 64'd18, 64'd20, 64'd22, 64'd0, 64'd0};
    e2s  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd27, 64'd30, 64'd33, 64'd0};
    e3s  = '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd27, 64'd48, 64'd53};
    epop = 8'b0000_1110;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 3) drive(data_t'(9 + k), data_t'(9 + k), data_t'(9 + k), 3'b111);
      else       drive('0, '0, '0, 3'b000);
      #1;
      if (k < 3) check($sformatf("b2b%0d_push_valid", k), q_push_valid, 1'b1);
      check($sformatf("b2b%0d_pop_valid", k), q_pop_valid, epop[k]);
      check($sformatf("b2b%0d_out0", k), output_0, e0s[k]);
      check($sformatf("b2b%0d_out1", k), output_1, e0s[k]);
      check($sformatf("b2b%0d_out2", k), output_2, e2s[k]);
      check($sformatf("b2b%0d_out3", k), output_3, e3s[k]);
    end

    // en low freezes the queue and pipeline; evaluation resumes afterwards.
    do_reset();
    step();
    drive(64'd5, 64'd6, 64'd7, 3'b111);
    step();
    drive('0, '0, '0, 3'b000);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("en0_%0d_pop", k), {q_pop, q_pop_valid}, 2'b00);
      check($sformatf("en0_%0d_aktv", k), any_aktv(), 1'b0);
      step();
    end
    en = 1'b1;
    #1;
    check("en1_pop_valid", q_pop_valid, 1'b1);
    step();
    step();
    check("en1_out0", output_0, 64'd11);
    check("en1_aktv0", output_0_aktv, 1'b1);

    // Sliding window over two periods.
    do_reset();
    exp4 = '{64'd3, 64'd3, 64'd0};
    step();
    drive(64'd1, '0, '0, 3'b001);
    step();
    drive(64'd2, '0, '0, 3'b001);
    step();
    drive('0, '0, '0, 3'b000);
    seen = 0;
    slides = 0;
    prev_slide = 1'b0;
    for (int k = 0; k < 3 * P + 20 && seen < 3; k++) begin
      step();
      if (output_4_aktv) begin
        check($sformatf("win%0d_out4", seen), output_4, exp4[seen]);
        check($sformatf("win%0d_after_slide", seen), prev_slide, 1'b1);
        seen++;
      end
      if (slide_0) slides++;
      prev_slide = slide_0;
    end
    check("win_evals", seen, 3);
    check("win_slides", slides, 3);

    // Reset with entries still queued and in flight.
    step();
    for (int k = 0; k < 3; k++) begin
      drive(data_t'(9 + k), data_t'(9 + k), data_t'(9 + k), 3'b111);
      step();
    end
    drive('0, '0, '0, 3'b000);
    #1;
    check("rst_pre_aktv0", output_0_aktv, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async_outs", output_0 | output_1 | output_2 | output_3 | output_4, 64'd0);
    check("rst_async_aktv", any_aktv(), 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rst_idle%0d", k), {any_aktv(), q_pop_valid, pacing_in0, slide_0}, 4'b0000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
